// File: rtl/pipe_add_unit.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into STAGES registered segments.
// Optional ADD_SAT_EN clamps signed-overflowing results to signed max/min.
module pipe_add_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [SEG:0]      seg_sum [STAGES];

    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  res_nxt;
    logic              a_msb;
    logic              b_msb;
    logic              ovf_nxt;

    logic [WIDTH-1:0]  out_q;
    logic              ovf_q;
    logic              zero_q;

    // Stage k can advance unless it and every stage after it is full and the consumer stalls.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready || !(&(v_q | ((STAGES'(1) << k) - STAGES'(1))));
        end
    end

    assign in_ready = rdy[0];

    always_comb begin
        v_in  = '0;
        c_in  = '0;
        c_nxt = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_in[k]    = '0;
            b_in[k]    = '0;
            s_in[k]    = '0;
            s_nxt[k]   = '0;
            seg_sum[k] = '0;
        end

        // Subtraction enters as A + ~B + 1; the inverted operand travels down the pipe.
        v_in[0] = in_valid;
        a_in[0] = in_1;
        b_in[0] = in_sub ? ~in_2 : in_2;
        c_in[0] = in_sub;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
            s_in[k] = s_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            seg_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                       + {1'b0, b_in[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_in[k]};
            s_nxt[k]   = s_in[k];
            s_nxt[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
            c_nxt[k]   = seg_sum[k][SEG];
        end
    end

    always_comb begin
        raw     = s_nxt[LAST];
        a_msb   = a_in[LAST][WIDTH-1];
        b_msb   = b_in[LAST][WIDTH-1];
        ovf_nxt = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);
`ifdef ADD_SAT_EN
        if (ovf_nxt) begin
            res_nxt = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_nxt = raw;
        end
`else
        res_nxt = raw;
`endif
    end

    // Payload only loads with a valid op, so a stalled or idle stage keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        c_q[k] <= c_nxt[k];
                    end
                end
            end
            for (int k = 0; k < LAST; k++) begin
                if (rdy[k] && v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                    s_q[k] <= s_nxt[k];
                end
            end
            if (rdy[LAST] && v_in[LAST]) begin
                out_q  <= res_nxt;
                ovf_q  <= ovf_nxt;
                zero_q <= (res_nxt == '0);
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign out_carry = c_q[LAST];
    assign out       = out_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_add_unit.sv
// Directed bench for pipe_add_unit: 32-bit/4-stage instance plus an 8-bit/1-stage instance.
// Expected results are hand-computed; ADD_SAT_EN selects the saturated expectations.
module tb_pipe_add_unit;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;

    logic        n8_in_valid;
    logic        n8_in_ready;
    logic [7:0]  n8_in_1;
    logic [7:0]  n8_in_2;
    logic        n8_in_sub;
    logic        n8_out_valid;
    logic        n8_out_ready;
    logic [7:0]  n8_out;
    logic        n8_out_carry;
    logic        n8_out_ovf;
    logic        n8_out_zero;

    int pass_count = 0;
    int total_count = 0;
    int issued;
    int retired;

`ifdef ADD_SAT_EN
    localparam logic [31:0] EXP_POS_OVF_OUT  = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_NEG_OVF_OUT  = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG_OVF_ZERO = 32'd0;
`else
    localparam logic [31:0] EXP_POS_OVF_OUT  = 32'h8000_0000;
    localparam logic [31:0] EXP_NEG_OVF_OUT  = 32'h0000_0000;
    localparam logic [31:0] EXP_NEG_OVF_ZERO = 32'd1;
`endif

    pipe_add_unit #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    pipe_add_unit #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n8_in_valid),
        .in_ready  (n8_in_ready),
        .in_1      (n8_in_1),
        .in_2      (n8_in_2),
        .in_sub    (n8_in_sub),
        .out_valid (n8_out_valid),
        .out_ready (n8_out_ready),
        .out       (n8_out),
        .out_carry (n8_out_carry),
        .out_ovf   (n8_out_ovf),
        .out_zero  (n8_out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        in_1      = a;
        in_2      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    // One op through the 4-stage pipe: not visible after 3 edges, visible after the 4th.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] exp_out, input logic exp_c, input logic exp_o, input logic exp_z);
        applyStimulus(a, b, sub);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_out"},   out, exp_out);
        checkOutput({tag, "_carry"}, {31'd0, out_carry}, {31'd0, exp_c});
        checkOutput({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, exp_o});
        checkOutput({tag, "_zero"},  {31'd0, out_zero},  {31'd0, exp_z});
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_1         = '0;
        in_2         = '0;
        in_sub       = 1'b0;
        out_ready    = 1'b0;
        n8_in_valid  = 1'b0;
        n8_in_1      = '0;
        n8_in_2      = '0;
        n8_in_sub    = 1'b0;
        n8_out_ready = 1'b0;

        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out",       out, 32'd0);
        checkOutput("rst_flags",     {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        checkOutput("rst8_state",    {23'd0, n8_out_valid, n8_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOp("add_wrap",  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runOp("add_povf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, EXP_POS_OVF_OUT, 1'b0, 1'b1, 1'b0);
        runOp("add_novf",  32'h8000_0000, 32'h8000_0000, 1'b0, EXP_NEG_OVF_OUT, 1'b1, 1'b1, EXP_NEG_OVF_ZERO[0]);
        runOp("sub_neg",   32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        runOp("sub_eq",    32'd9, 32'd9, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        runOp("add_plain", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0);

        // Eight streamed ops (i + 100) with the consumer stalled for cycles 2..7.
        @(posedge clk); #1;
        issued  = 0;
        retired = 0;
        for (int cyc = 0; cyc < 60 && retired < 8; cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 8);
            in_valid  = (issued < 8);
            in_1      = 32'(issued);
            in_2      = 32'd100;
            in_sub    = 1'b0;
            #1;
            if (cyc == 2) checkOutput("stream_ready_partial", {31'd0, in_ready}, 32'd1);
            if (cyc == 4) checkOutput("stream_ready_full", {31'd0, in_ready}, 32'd0);
            if (cyc == 7) checkOutput("stream_ready_full_end", {31'd0, in_ready}, 32'd0);
            if (cyc == 8) checkOutput("stream_ready_release", {31'd0, in_ready}, 32'd1);
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_order%0d", retired), out, 32'(retired + 100));
                retired++;
            end
            if (in_valid && in_ready) issued++;
            @(posedge clk); #1;
        end
        checkOutput("stream_retired", 32'(retired), 32'd8);
        checkOutput("stream_issued",  32'(issued),  32'd8);
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);

        // Three ops in flight, consumer stalled, then an asynchronous reset mid-cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_1     = 32'(i + 1);
            in_2     = 32'd1;
            in_sub   = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("inflight_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_out",   out, 32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("post_rst_discarded", {31'd0, out_valid}, 32'd0);
        runOp("post_rst", 32'd40, 32'd2, 1'b0, 32'd42, 1'b0, 1'b0, 1'b0);

        // Single-stage 8-bit instance: result one edge after accept.
        n8_in_1      = 8'hFF;
        n8_in_2      = 8'h01;
        n8_in_sub    = 1'b0;
        n8_in_valid  = 1'b1;
        n8_out_ready = 1'b1;
        #1;
        checkOutput("w8_in_ready", {31'd0, n8_in_ready}, 32'd1);
        @(posedge clk); #1;
        n8_in_valid = 1'b0;
        checkOutput("w8_valid", {31'd0, n8_out_valid}, 32'd1);
        checkOutput("w8_out",   {24'd0, n8_out}, 32'd0);
        checkOutput("w8_flags", {29'd0, n8_out_carry, n8_out_ovf, n8_out_zero}, 32'b101);
        @(posedge clk); #1;
        checkOutput("w8_retired", {31'd0, n8_out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
